// File: rtl/player_bullet.sv
// Player shot engine: bullet slot pool with fire cooldown, upward motion and per-enemy hit pulses.
// Define PLAYER_BULLET_HIT_CNT_EN to build the saturating total-hit counter; otherwise hit_cnt is 0.
module player_bullet #(
    parameter int N_BULLET  = 4,
    parameter int SPEED     = 12,
    parameter int COOLDOWN  = 5,
    parameter int SPAWN_OFS = 16,
    parameter int HIT_W     = 12,
    parameter int HIT_H     = 12,
    parameter int Y_MIN     = 8
) (
    input  logic                    clk22,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    fire,
    input  logic [9:0]              reimux,
    input  logic [9:0]              reimuy,
    input  logic [9:0]              enmx1,
    input  logic [9:0]              enmx2,
    input  logic [9:0]              enmx3,
    input  logic [9:0]              enmx4,
    input  logic [9:0]              enmy1,
    input  logic [9:0]              enmy2,
    input  logic [9:0]              enmy3,
    input  logic [9:0]              enmy4,
    input  logic                    enm1,
    input  logic                    enm2,
    input  logic                    enm3,
    input  logic                    enm4,
    output logic                    hit1,
    output logic                    hit2,
    output logic                    hit3,
    output logic                    hit4,
    output logic [N_BULLET-1:0]     bullet,
    output logic [10*N_BULLET-1:0]  bulletx,
    output logic [10*N_BULLET-1:0]  bullety,
    output logic [15:0]             hit_cnt
);

    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
    localparam logic [10:0]     HW_11   = 11'(HIT_W);
    localparam logic [10:0]     HH_11   = 11'(HIT_H);
    localparam logic [9:0]      SPEED_V = 10'(SPEED);
    localparam logic [9:0]      OFS_V   = 10'(SPAWN_OFS);
    localparam logic [9:0]      Y_RET   = 10'(Y_MIN + SPEED);
    localparam logic [9:0]      Y_SPAWN = 10'(Y_MIN + SPAWN_OFS);

    logic [9:0] ex [4];
    logic [9:0] ey [4];
    logic [3:0] ea;

    assign ex[0] = enmx1;
    assign ex[1] = enmx2;
    assign ex[2] = enmx3;
    assign ex[3] = enmx4;
    assign ey[0] = enmy1;
    assign ey[1] = enmy2;
    assign ey[2] = enmy3;
    assign ey[3] = enmy4;
    assign ea    = {enm4, enm3, enm2, enm1};

    logic [CD_W-1:0]          cd;
    logic [CD_W-1:0]          cd_nxt;
    logic [3:0]               hit_q;
    logic [3:0]               hit_nxt;
    logic [N_BULLET-1:0]      bullet_nxt;
    logic [10*N_BULLET-1:0]   bx_nxt;
    logic [10*N_BULLET-1:0]   by_nxt;
    logic [9:0]               bx_cur;
    logic [9:0]               by_cur;
    logic                     found;
    logic                     spawned;

    always_comb begin
        bullet_nxt = bullet;
        bx_nxt     = bulletx;
        by_nxt     = bullety;
        hit_nxt    = '0;
        bx_cur     = '0;
        by_cur     = '0;
        found      = 1'b0;
        spawned    = 1'b0;
        cd_nxt     = (cd != '0) ? cd - CD_W'(1) : cd;

        // Slots are judged on their registered position; the lowest live enemy wins an overlap.
        for (int i = 0; i < N_BULLET; i++) begin
            if (bullet[i]) begin
                bx_cur = bulletx[10*i +: 10];
                by_cur = bullety[10*i +: 10];
                found  = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && ea[k]
                        && (({1'b0, bx_cur} + HW_11) > {1'b0, ex[k]})
                        && ({1'b0, bx_cur} < ({1'b0, ex[k]} + HW_11))
                        && (({1'b0, by_cur} + HH_11) > {1'b0, ey[k]})
                        && ({1'b0, by_cur} < ({1'b0, ey[k]} + HH_11))) begin
                        found      = 1'b1;
                        hit_nxt[k] = 1'b1;
                    end
                end
                if (found || (by_cur < Y_RET)) begin
                    bullet_nxt[i]       = 1'b0;
                    bx_nxt[10*i +: 10]  = '0;
                    by_nxt[10*i +: 10]  = '0;
                end else begin
                    by_nxt[10*i +: 10]  = by_cur - SPEED_V;
                end
            end
        end

        // Free means free before this edge, so a slot vacated above is not reused yet.
        if (fire && (cd == '0) && (reimuy >= Y_SPAWN)) begin
            for (int i = 0; i < N_BULLET; i++) begin
                if (!spawned && !bullet[i]) begin
                    spawned            = 1'b1;
                    bullet_nxt[i]      = 1'b1;
                    bx_nxt[10*i +: 10] = reimux;
                    by_nxt[10*i +: 10] = reimuy - OFS_V;
                end
            end
        end
        if (spawned) begin
            cd_nxt = CD_LOAD;
        end
    end

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            bullet  <= '0;
            bulletx <= '0;
            bullety <= '0;
            hit_q   <= '0;
            cd      <= '0;
        end else if (clr) begin
            bullet  <= '0;
            bulletx <= '0;
            bullety <= '0;
            hit_q   <= '0;
            cd      <= '0;
        end else begin
            bullet  <= bullet_nxt;
            bulletx <= bx_nxt;
            bullety <= by_nxt;
            hit_q   <= hit_nxt;
            cd      <= cd_nxt;
        end
    end

    assign hit1 = hit_q[0];
    assign hit2 = hit_q[1];
    assign hit3 = hit_q[2];
    assign hit4 = hit_q[3];

`ifdef PLAYER_BULLET_HIT_CNT_EN
    logic [2:0]  hit_pop;
    logic [16:0] cnt_sum;
    logic [15:0] cnt_q;

    assign hit_pop = {2'b0, hit_nxt[0]} + {2'b0, hit_nxt[1]}
                   + {2'b0, hit_nxt[2]} + {2'b0, hit_nxt[3]};
    assign cnt_sum = {1'b0, cnt_q} + {14'b0, hit_pop};

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    assign hit_cnt = cnt_q;
`else
    assign hit_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet: per-cycle vector table plus hand sequences for pool, retire, clr and async reset.
module tb_player_bullet;

`ifdef PLAYER_BULLET_HIT_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic        clk22 = 1'b0;
    logic        rst   = 1'b1;
    logic        clr   = 1'b0;
    logic        fire  = 1'b0;
    logic [9:0]  reimux = '0;
    logic [9:0]  reimuy = '0;
    logic [9:0]  ex = '0;
    logic [9:0]  ey = '0;
    logic [3:0]  en = '0;
    logic        hit1, hit2, hit3, hit4;
    logic [3:0]  bullet;
    logic [39:0] bulletx;
    logic [39:0] bullety;
    logic [15:0] hit_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk22 = ~clk22;

    player_bullet dut (
        .clk22   (clk22),
        .rst     (rst),
        .clr     (clr),
        .fire    (fire),
        .reimux  (reimux),
        .reimuy  (reimuy),
        .enmx1   (ex),
        .enmx2   (ex),
        .enmx3   (ex),
        .enmx4   (ex),
        .enmy1   (ey),
        .enmy2   (ey),
        .enmy3   (ey),
        .enmy4   (ey),
        .enm1    (en[0]),
        .enm2    (en[1]),
        .enm3    (en[2]),
        .enm4    (en[3]),
        .hit1    (hit1),
        .hit2    (hit2),
        .hit3    (hit3),
        .hit4    (hit4),
        .bullet  (bullet),
        .bulletx (bulletx),
        .bullety (bullety),
        .hit_cnt (hit_cnt)
    );

    typedef struct {
        logic       fire;
        logic [9:0] rx;
        logic [9:0] ry;
        logic [3:0] en;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [3:0] e_bul;
        logic [9:0] e_x0;
        logic [9:0] e_y0;
        logic [3:0] e_hit;
        int         e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic f, input int rx, input int ry, input logic [3:0] e,
                       input int x, input int y, input logic [3:0] bul, input int x0,
                       input int y0, input logic [3:0] h, input int c);
        vec_t v;
        v.fire = f;  v.rx = 10'(rx); v.ry = 10'(ry); v.en = e;
        v.ex = 10'(x); v.ey = 10'(y); v.e_bul = bul; v.e_x0 = 10'(x0);
        v.e_y0 = 10'(y0); v.e_hit = h; v.e_cnt = c;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk22);
        #1;
    endtask

    task automatic do_reset();
        fire = 1'b0; clr = 1'b0; en = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk22);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [9:0] yslot(input int s);
        logic [39:0] t;
        t = bullety;
        return t[10*s +: 10];
    endfunction

    function automatic logic [9:0] xslot(input int s);
        logic [39:0] t;
        t = bulletx;
        return t[10*s +: 10];
    endfunction

    logic [3:0] hit_acc;

    initial begin
        // Table: inputs before the edge, expected outputs just after it.
        add(1, 200, 400, 4'b0000, 200, 300, 4'b0001, 200, 384, 4'b0000, 0);
        add(0, 200, 400, 4'b0000, 200, 300, 4'b0001, 200, 372, 4'b0000, 0);
        add(0, 200, 400, 4'b0000, 200, 300, 4'b0001, 200, 360, 4'b0000, 0);
        add(0, 200, 400, 4'b0001, 200, 300, 4'b0001, 200, 348, 4'b0000, 0);
        add(0, 200, 400, 4'b0001, 200, 300, 4'b0001, 200, 336, 4'b0000, 0);
        add(0, 200, 400, 4'b0001, 200, 300, 4'b0001, 200, 324, 4'b0000, 0);
        add(0, 200, 400, 4'b0001, 200, 300, 4'b0001, 200, 312, 4'b0000, 0);
        add(0, 200, 400, 4'b0001, 200, 300, 4'b0001, 200, 300, 4'b0000, 0);
        add(0, 200, 400, 4'b0001, 200, 300, 4'b0000,   0,   0, 4'b0001, 1);
        add(0, 200, 400, 4'b0001, 200, 300, 4'b0000,   0,   0, 4'b0000, 1);
        add(1, 200, 400, 4'b0000, 212, 384, 4'b0001, 200, 384, 4'b0000, 1);
        add(0, 200, 400, 4'b0001, 212, 384, 4'b0001, 200, 372, 4'b0000, 1);
        add(0, 200, 400, 4'b0001, 211, 372, 4'b0000,   0,   0, 4'b0001, 2);
        add(0, 200, 400, 4'b0000, 200, 300, 4'b0000,   0,   0, 4'b0000, 2);
        add(0, 200, 400, 4'b0000, 200, 300, 4'b0000,   0,   0, 4'b0000, 2);
        add(0, 200, 400, 4'b0000, 200, 300, 4'b0000,   0,   0, 4'b0000, 2);
        add(1, 200, 400, 4'b0000, 200, 384, 4'b0001, 200, 384, 4'b0000, 2);
        add(0, 200, 400, 4'b0011, 200, 384, 4'b0000,   0,   0, 4'b0001, 3);
        add(0, 200, 400, 4'b0110, 200, 384, 4'b0000,   0,   0, 4'b0000, 3);
        add(0, 200, 400, 4'b0000, 200, 384, 4'b0000,   0,   0, 4'b0000, 3);
        add(0, 200, 400, 4'b0000, 200, 384, 4'b0000,   0,   0, 4'b0000, 3);
        add(0, 200, 400, 4'b0000, 200, 384, 4'b0000,   0,   0, 4'b0000, 3);
        add(1, 200, 400, 4'b0000, 200, 384, 4'b0001, 200, 384, 4'b0000, 3);
        add(0, 200, 400, 4'b0110, 200, 384, 4'b0000,   0,   0, 4'b0010, 4);
        add(0, 200, 400, 4'b0000, 200, 384, 4'b0000,   0,   0, 4'b0000, 4);
        add(0, 200, 400, 4'b0000, 200, 384, 4'b0000,   0,   0, 4'b0000, 4);
        add(0, 200, 400, 4'b0000, 200, 384, 4'b0000,   0,   0, 4'b0000, 4);
        add(0, 200, 400, 4'b0000, 200, 384, 4'b0000,   0,   0, 4'b0000, 4);
        add(1, 200,  23, 4'b0000, 200, 384, 4'b0000,   0,   0, 4'b0000, 4);
        add(1,   5,  24, 4'b0000, 200, 384, 4'b0001,   5,   8, 4'b0000, 4);
        add(0,   5,  24, 4'b0000, 200, 384, 4'b0000,   0,   0, 4'b0000, 4);

        #2;
        check("reset_bullet", 32'(bullet), 32'd0);
        check("reset_hits", 32'({hit4, hit3, hit2, hit1}), 32'd0);
        check("reset_cnt", 32'(hit_cnt), 32'd0);
        do_reset();

        foreach (vecs[i]) begin
            fire = vecs[i].fire; reimux = vecs[i].rx; reimuy = vecs[i].ry;
            en = vecs[i].en; ex = vecs[i].ex; ey = vecs[i].ey;
            step();
            check($sformatf("vec%0d_bullet", i), 32'(bullet), 32'(vecs[i].e_bul));
            check($sformatf("vec%0d_x0", i), 32'(xslot(0)), 32'(vecs[i].e_x0));
            check($sformatf("vec%0d_y0", i), 32'(yslot(0)), 32'(vecs[i].e_y0));
            check($sformatf("vec%0d_hits", i), 32'({hit4, hit3, hit2, hit1}), 32'(vecs[i].e_hit));
            check($sformatf("vec%0d_cnt", i), 32'(hit_cnt), 32'(CNT_ON * vecs[i].e_cnt));
        end

        // Pool and cooldown with fire held; reimux tracks the cycle number to tag each spawn.
        do_reset();
        en = '0; reimuy = 10'd400; fire = 1'b1;
        for (int c = 0; c < 40; c++) begin
            reimux = 10'(100 + c);
            step();
            case (c)
                0:  begin check("pool0_bul", 32'(bullet), 32'b0001); check("pool0_y0", 32'(yslot(0)), 32'd384); end
                5:  check("pool5_bul", 32'(bullet), 32'b0001);
                6:  begin check("pool6_bul", 32'(bullet), 32'b0011); check("pool6_x1", 32'(xslot(1)), 32'd106);
                          check("pool6_y0", 32'(yslot(0)), 32'd312); end
                12: check("pool12_bul", 32'(bullet), 32'b0111);
                18: begin check("pool18_bul", 32'(bullet), 32'b1111); check("pool18_x3", 32'(xslot(3)), 32'd118); end
                24: check("pool24_y0", 32'(yslot(0)), 32'd96);
                31: begin check("pool31_bul", 32'(bullet), 32'b1111); check("pool31_y0", 32'(yslot(0)), 32'd12); end
                32: begin check("pool32_bul", 32'(bullet), 32'b1110); check("pool32_x0", 32'(xslot(0)), 32'd0); end
                33: begin check("pool33_bul", 32'(bullet), 32'b1111); check("pool33_x0", 32'(xslot(0)), 32'd133);
                          check("pool33_y0", 32'(yslot(0)), 32'd384); end
                38: begin check("pool38_bul", 32'(bullet), 32'b1101); check("pool38_y1", 32'(yslot(1)), 32'd0); end
                39: begin check("pool39_bul", 32'(bullet), 32'b1111); check("pool39_x1", 32'(xslot(1)), 32'd139);
                          check("pool39_y2", 32'(yslot(2)), 32'd60); end
                default: ;
            endcase
        end
        fire = 1'b0;

        // Dead enemy sitting on the path: no hit, bullet retires after 31 moves.
        do_reset();
        ex = 10'd200; ey = 10'd300; en = 4'b0000;
        fire = 1'b1; reimux = 10'd200; reimuy = 10'd400;
        step();
        fire = 1'b0;
        hit_acc = '0;
        for (int k = 1; k <= 32; k++) begin
            step();
            hit_acc = hit_acc | {hit4, hit3, hit2, hit1};
            if (k == 31) begin
                check("dead_k31_bul", 32'(bullet), 32'b0001);
                check("dead_k31_y0", 32'(yslot(0)), 32'd12);
            end
        end
        check("dead_retired", 32'(bullet), 32'd0);
        check("dead_nohit", 32'(hit_acc), 32'd0);
        check("dead_cnt", 32'(hit_cnt), 32'd0);

        // Synchronous clear with two bullets in flight; cooldown must be cleared too.
        do_reset();
        fire = 1'b1; reimux = 10'd50; reimuy = 10'd400;
        repeat (7) step();
        check("clr_pre_bul", 32'(bullet), 32'b0011);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_bul", 32'(bullet), 32'd0);
        check("clr_x", 32'(bulletx), 32'd0);
        check("clr_y", 32'(bullety), 32'd0);
        step();
        check("clr_cd_ready", 32'(bullet), 32'b0001);
        fire = 1'b0;

        // Async reset mid-cycle must zero outputs before the next edge.
        repeat (6) step();
        fire = 1'b1;
        step();
        check("arst_pre_bul", 32'(bullet), 32'b0011);
        #3;
        rst = 1'b1;
        #1;
        check("arst_bul", 32'(bullet), 32'd0);
        check("arst_x", 32'(bulletx), 32'd0);
        check("arst_y", 32'(bullety), 32'd0);
        #1;
        rst = 1'b0;
        step();
        check("arst_cd_ready", 32'(bullet), 32'b0001);
        fire = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
